run_ctrl: RTL and testbench

Parametrised execution controller for the single-cycle CPU datapath, generalising the existing syscall pause/display logic. It gates the PC register via `pc_enable` and decodes syscalls into three actions: halt, pause or show a value. It adds single-step mode, a PC breakpoint, saturating performance counters and a registered display-source mux feeding the 7-segment display driver.

---
 rtl/run_ctrl_pkg.sv | 30 +++
 rtl/sync_edge.sv | 31 +++
 rtl/run_ctrl.sv | 151 +++++++++++++++
 tb/tb_run_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the execution controller.
//   state_t    - controller state (RUN / PAUSE / HALT)
//   SYS_*      - syscall codes ($v0) with special meaning
//   DSEL_*     - disp_sel source codes
//   CNT_*      - index of each performance counter in the counter bank
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int SYS_HALT = 10;
  localparam int SYS_SHOW = 34;

  localparam logic [2:0] DSEL_SHOW = 3'd0;
  localparam logic [2:0] DSEL_INST = 3'd1;
  localparam logic [2:0] DSEL_JUMP = 3'd2;
  localparam logic [2:0] DSEL_BR   = 3'd3;
  localparam logic [2:0] DSEL_CYC  = 3'd4;
  localparam logic [2:0] DSEL_PC   = 3'd5;

  localparam int CNT_CYC  = 0;
  localparam int CNT_INST = 1;
  localparam int CNT_JUMP = 2;
  localparam int CNT_BR   = 3;
  localparam int CNT_NUM  = 4;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchroniser for an asynchronous button level followed by
// a rising-edge detector.
//   clk  - destination clock
//   rst  - synchronous active-high reset
//   din  - raw asynchronous level
//   rise - one-cycle pulse, two cycles after din goes high
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [1:0] sync_reg;
  logic       prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], din};
      prev_reg <= sync_reg[1];
    end
  end

  // Pulse is taken straight off the second flop so the press is usable in
  // the same cycle the synchronised level first appears.
  assign rise = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: execution controller for the single-cycle CPU datapath.
// Gates the PC write, decodes halt/pause/show syscalls, supports single-step
// and a PC breakpoint, keeps saturating performance counters and drives a
// registered display mux.
//   clk, rst             - clock, synchronous active-high reset
//   go                   - raw resume/step button
//   step_mode            - retire at most one instruction per go press
//   bp_en, bp_addr       - breakpoint enable and address
//   pc_val               - PC of the instruction currently executing
//   syscall, sys_v0/a0   - syscall flag, code and argument
//   is_jump, is_br_taken - instruction class for the counters
//   disp_sel             - display source select
//   pc_enable            - PC write enable (combinational)
//   paused, halted       - state flags
//   disp_data            - registered display value
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              step_mode,
  input  logic              bp_en,
  input  logic [DATA_W-1:0] bp_addr,
  input  logic [DATA_W-1:0] pc_val,
  input  logic              syscall,
  input  logic [DATA_W-1:0] sys_v0,
  input  logic [DATA_W-1:0] sys_a0,
  input  logic              is_jump,
  input  logic              is_br_taken,
  input  logic [2:0]        disp_sel,
  output logic              pc_enable,
  output logic              paused,
  output logic              halted,
  output logic [DATA_W-1:0] disp_data
);

  state_t            state_reg, state_next;
  logic              bp_skip_reg, bp_skip_next;
  logic [DATA_W-1:0] show_reg, show_next;
  logic [DATA_W-1:0] disp_reg, disp_next;

  logic go_rise;
  logic exec, bp_hit, halt_sys, show_sys, stop, retire;

  sync_edge u_go_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (go),
    .rise (go_rise)
  );

  assign exec     = (state_reg == ST_RUN) | ((state_reg == ST_PAUSE) & go_rise);
  // bp_skip lets the breakpointed instruction execute once on resume.
  assign bp_hit   = bp_en & (pc_val == bp_addr) & ~bp_skip_reg;
  assign halt_sys = syscall & (sys_v0 == DATA_W'(SYS_HALT));
  assign show_sys = syscall & (sys_v0 == DATA_W'(SYS_SHOW));
  assign stop     = bp_hit | halt_sys;
  assign retire   = exec & ~stop;

  assign pc_enable = retire & ~rst;
  assign paused    = (state_reg == ST_PAUSE);
  assign halted    = (state_reg == ST_HALT);
  assign disp_data = disp_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_RUN;
      bp_skip_reg <= 1'b0;
      show_reg    <= '0;
      disp_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      bp_skip_reg <= bp_skip_next;
      show_reg    <= show_next;
      disp_reg    <= disp_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bp_skip_next = bp_skip_reg;
    show_next    = show_reg;
    if (exec) begin
      if (bp_hit) begin
        state_next   = ST_PAUSE;
        bp_skip_next = 1'b1;
      end else if (halt_sys) begin
        state_next = ST_HALT;
      end else begin
        bp_skip_next = 1'b0;
        if (show_sys) begin
          show_next  = sys_a0;
          state_next = step_mode ? ST_PAUSE : ST_RUN;
        end else if (syscall) begin
          state_next = ST_PAUSE;
        end else begin
          state_next = step_mode ? ST_PAUSE : ST_RUN;
        end
      end
    end
  end

  // Counter bank: one saturating counter per generate slice, each exposed
  // already resized to DATA_W for the display mux.
  logic [CNT_NUM-1:0]             cnt_inc;
  logic [CNT_NUM-1:0][DATA_W-1:0] cnt_view;

  always_comb begin
    cnt_inc           = '0;
    cnt_inc[CNT_CYC]  = (state_reg != ST_HALT);
    cnt_inc[CNT_INST] = retire;
    cnt_inc[CNT_JUMP] = retire & is_jump;
    cnt_inc[CNT_BR]   = retire & is_br_taken;
  end

  for (genvar gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end

    if (CNT_W >= DATA_W) begin : g_trunc
      assign cnt_view[gi] = cnt_reg[DATA_W-1:0];
    end else begin : g_zext
      assign cnt_view[gi] = {{(DATA_W-CNT_W){1'b0}}, cnt_reg};
    end
  end

  always_comb begin
    disp_next = '0;
    case (disp_sel)
      DSEL_SHOW: disp_next = show_reg;
      DSEL_INST: disp_next = cnt_view[CNT_INST];
      DSEL_JUMP: disp_next = cnt_view[CNT_JUMP];
      DSEL_BR:   disp_next = cnt_view[CNT_BR];
      DSEL_CYC:  disp_next = cnt_view[CNT_CYC];
      DSEL_PC:   disp_next = pc_val;
      default:   disp_next = '0;
    endcase
  end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl. A second instance
// with 4-bit counters, free-running with quiet inputs, covers saturation.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        go, step_mode, bp_en, syscall, is_jump, is_br_taken;
  logic [31:0] bp_addr, pc_val, sys_v0, sys_a0;
  logic [2:0]  disp_sel;
  logic        pc_enable, paused, halted;
  logic [31:0] disp_data;

  logic        pc_enable_s, paused_s, halted_s;
  logic [31:0] disp_data_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  run_ctrl #(.DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .go(go), .step_mode(step_mode), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc_val(pc_val), .syscall(syscall), .sys_v0(sys_v0),
    .sys_a0(sys_a0), .is_jump(is_jump), .is_br_taken(is_br_taken),
    .disp_sel(disp_sel), .pc_enable(pc_enable), .paused(paused),
    .halted(halted), .disp_data(disp_data)
  );

  run_ctrl #(.DATA_W(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .go(1'b0), .step_mode(1'b0), .bp_en(1'b0),
    .bp_addr(32'h0), .pc_val(32'h0), .syscall(1'b0), .sys_v0(32'h0),
    .sys_a0(32'h0), .is_jump(1'b0), .is_br_taken(1'b0),
    .disp_sel(3'd4), .pc_enable(pc_enable_s), .paused(paused_s),
    .halted(halted_s), .disp_data(disp_data_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Hold go across several edges: only one retire may result.
  task automatic press_go();
    go = 1'b1;
    repeat (5) tick();
    go = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    go = 0; step_mode = 0; bp_en = 0; syscall = 0; is_jump = 0; is_br_taken = 0;
    bp_addr = 32'h0C; pc_val = 32'h0; sys_v0 = 0; sys_a0 = 0; disp_sel = 3'd0;
    rst = 1'b1;
    #1;
    tick();
    tick();
    check("pc_enable_in_reset", pc_enable, 1'b0);
    rst = 1'b0;
    check("reset_paused", paused, 1'b0);
    check("reset_halted", halted, 1'b0);
    check("reset_disp", disp_data, 32'h0);

    // Saturation on the 4-bit instance: after edge n cyc = min(n,15),
    // disp shows the pre-edge value.
    repeat (20) tick();
    check("sat_cyc_20", disp_data_s, 32'd15);
    repeat (10) tick();
    check("sat_cyc_30", disp_data_s, 32'd15);
    check("sat_not_halted", halted_s, 1'b0);
    check("sat_pc_enable", pc_enable_s, 1'b1);

    // Show syscall
    do_reset();
    syscall = 1; sys_v0 = 34; sys_a0 = 32'h1234; disp_sel = 3'd0;
    #1;
    check("show_pc_enable", pc_enable, 1'b1);
    tick();
    syscall = 0;
    tick();
    check("show_disp", disp_data, 32'h1234);
    check("show_not_paused", paused, 1'b0);

    // Pause syscall and resume
    syscall = 1; sys_v0 = 5;
    #1;
    check("pause_sys_pc_enable", pc_enable, 1'b1);
    tick();
    syscall = 0;
    check("pause_sys_paused", paused, 1'b1);
    check("pause_hold_pc_enable", pc_enable, 1'b0);
    go = 1;
    tick();
    check("pause_go_sync1", pc_enable, 1'b0);
    tick();
    check("pause_go_rise_pc_enable", pc_enable, 1'b1);
    tick();
    check("pause_resumed", paused, 1'b0);
    go = 0;
    repeat (3) tick();

    // Halt syscall
    syscall = 1; sys_v0 = 10;
    #1;
    check("halt_pc_enable", pc_enable, 1'b0);
    tick();
    syscall = 0;
    check("halt_halted", halted, 1'b1);
    go = 1;
    repeat (4) tick();
    check("halt_ignores_go", halted, 1'b1);
    check("halt_pc_enable_go", pc_enable, 1'b0);
    go = 0;
    disp_sel = 3'd1;
    do_reset();
    tick();
    check("halt_rst_inst_zero", disp_data, 32'h0);
    check("halt_rst_run", halted, 1'b0);

    // Jump/branch counters on fresh counters
    do_reset();
    is_jump = 1;
    repeat (4) tick();
    is_jump = 0; is_br_taken = 1;
    repeat (2) tick();
    is_br_taken = 0;
    disp_sel = 3'd2;
    tick();
    check("jump_cnt", disp_data, 32'd4);
    disp_sel = 3'd3;
    tick();
    check("br_cnt", disp_data, 32'd2);

    // Breakpoint at 0x0C
    bp_en = 1; bp_addr = 32'h0C; pc_val = 32'h08; disp_sel = 3'd1;
    do_reset();
    tick();                       // retire at 0x08, inst = 1
    pc_val = 32'h0C;
    #1;
    check("bp_pc_enable", pc_enable, 1'b0);
    tick();
    check("bp_paused", paused, 1'b1);
    tick();
    check("bp_inst_before", disp_data, 32'd1);
    go = 1;
    tick();
    tick();
    check("bp_resume_pc_enable", pc_enable, 1'b1);
    tick();                       // retire at 0x0C, inst = 2
    pc_val = 32'h10; go = 0;
    check("bp_resumed_run", paused, 1'b0);
    tick();
    check("bp_inst_after", disp_data, 32'd2);
    repeat (3) tick();

    // Step mode: enter PAUSE via breakpoint without a retire, then 3 presses
    bp_en = 1; pc_val = 32'h0C; step_mode = 1; disp_sel = 3'd1;
    do_reset();
    tick();
    bp_en = 0;
    check("step_entry_paused", paused, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      press_go();
      pc_val = pc_val + 32'd4;
      check($sformatf("step%0d_paused", k), paused, 1'b1);
      check($sformatf("step%0d_inst", k), disp_data, k);
      check($sformatf("step%0d_pc_enable", k), pc_enable, 1'b0);
    end
    step_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
